ad_ip_jesd204_tpl_dac_dma_fifo: RTL and testbench

AD_IP_JESD204_TPL_DAC_DMA_FIFO -- requirements
Module: ad_ip_jesd204_tpl_dac_dma_fifo

---
 rtl/ad_ip_jesd204_tpl_dac_dma_fifo_pkg.sv | 22 ++
 rtl/ad_ip_jesd204_tpl_dac_dma_fifo_mem.sv | 35 +++
 rtl/ad_ip_jesd204_tpl_dac_dma_fifo.sv | 176 +++++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_dma_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo_pkg.sv
// Shared definitions for the TPL DAC DMA FIFO family: FSM state encodings
// and the saturating underflow counter helper.
package ad_ip_jesd204_tpl_dac_dma_fifo_pkg;

  localparam logic [1:0] TPL_DAC_ST_IDLE  = 2'd0;
  localparam logic [1:0] TPL_DAC_ST_PRIME = 2'd1;
  localparam logic [1:0] TPL_DAC_ST_RUN   = 2'd2;
  localparam logic [1:0] TPL_DAC_ST_FLUSH = 2'd3;

  localparam logic [15:0] TPL_DAC_UNF_CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == TPL_DAC_UNF_CNT_MAX) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo_mem.sv
// Simple dual-port sample memory for the DMA FIFO: one write port and one
// read port whose output register holds until the next read.
module ad_ip_jesd204_tpl_dac_dma_fifo_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo.sv
// DMA-to-TPL DAC sample FIFO: priming threshold, underflow tracking and
// flush on disable. Storage lives in the _mem sub-module.
module ad_ip_jesd204_tpl_dac_dma_fifo
  import ad_ip_jesd204_tpl_dac_dma_fifo_pkg::*;
#(
  parameter int DMA_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DMA_DATA_WIDTH-1:0] s_data,
  input  logic                      dac_valid,
  output logic [DMA_DATA_WIDTH-1:0] dac_ddata,
  input  logic                      ctrl_enable,
  input  logic [ADDR_WIDTH:0]       ctrl_threshold,
  output logic                      dac_dunf,
  input  logic                      dac_dunf_clr,
  output logic [15:0]               unf_count,
  output logic [ADDR_WIDTH:0]       fill_level
);

  localparam int                    DEPTH     = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   LVL_FULL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LVL_ZERO  = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [1:0]                r_state;
  logic [ADDR_WIDTH-1:0]     r_wr_ptr;
  logic [ADDR_WIDTH-1:0]     r_rd_ptr;
  logic [ADDR_WIDTH:0]       r_level;
  logic                      r_out_zero;
  logic                      r_dunf;
  logic [15:0]               r_unf_cnt;

  logic [1:0]                w_state_nxt;
  logic [ADDR_WIDTH:0]       w_level_nxt;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_active;
  logic                      w_clear;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_unf;
  logic [DMA_DATA_WIDTH-1:0] w_rd_data;

  assign w_full   = (r_level == LVL_FULL);
  assign w_empty  = (r_level == LVL_ZERO);
  assign w_active = (r_state == TPL_DAC_ST_PRIME) || (r_state == TPL_DAC_ST_RUN);
  assign w_clear  = (r_state == TPL_DAC_ST_IDLE) || (r_state == TPL_DAC_ST_FLUSH);
  assign s_ready  = w_active && !w_full;
  assign w_push   = s_valid && s_ready;
  assign w_pop    = (r_state == TPL_DAC_ST_RUN) && dac_valid && !w_empty;
  assign w_unf    = (r_state == TPL_DAC_ST_RUN) && dac_valid && w_empty;

  // Disable has priority over the priming threshold.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TPL_DAC_ST_IDLE: begin
        if (ctrl_enable) begin
          w_state_nxt = TPL_DAC_ST_PRIME;
        end else begin
          w_state_nxt = TPL_DAC_ST_IDLE;
        end
      end
      TPL_DAC_ST_PRIME: begin
        if (!ctrl_enable) begin
          w_state_nxt = TPL_DAC_ST_FLUSH;
        end else if ((r_level >= ctrl_threshold) || w_full) begin
          w_state_nxt = TPL_DAC_ST_RUN;
        end else begin
          w_state_nxt = TPL_DAC_ST_PRIME;
        end
      end
      TPL_DAC_ST_RUN: begin
        if (!ctrl_enable) begin
          w_state_nxt = TPL_DAC_ST_FLUSH;
        end else begin
          w_state_nxt = TPL_DAC_ST_RUN;
        end
      end
      TPL_DAC_ST_FLUSH: begin
        w_state_nxt = TPL_DAC_ST_IDLE;
      end
      default: begin
        w_state_nxt = TPL_DAC_ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_ONE;
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LVL_ONE;
    end else begin
      w_level_nxt = r_level;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= TPL_DAC_ST_IDLE;
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_level  <= LVL_ZERO;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_wr_ptr <= PTR_ZERO;
        r_rd_ptr <= PTR_ZERO;
        r_level  <= LVL_ZERO;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
        r_level <= w_level_nxt;
      end
    end
  end

  // The memory read register holds the last popped word; r_out_zero masks
  // it whenever the output must read as zero (idle, flush, underflow).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_zero <= 1'b1;
      r_dunf     <= 1'b0;
      r_unf_cnt  <= 16'd0;
    end else begin
      if (w_clear) begin
        r_out_zero <= 1'b1;
      end else if (w_pop) begin
        r_out_zero <= 1'b0;
      end else if (w_unf) begin
        r_out_zero <= 1'b1;
      end
      if (w_unf) begin
        r_dunf <= 1'b1;
      end else if (dac_dunf_clr) begin
        r_dunf <= 1'b0;
      end
      if (r_state == TPL_DAC_ST_FLUSH) begin
        r_unf_cnt <= 16'd0;
      end else if (w_unf) begin
        r_unf_cnt <= sat_inc16(r_unf_cnt);
      end
    end
  end

  ad_ip_jesd204_tpl_dac_dma_fifo_mem #(
    .DATA_WIDTH (DMA_DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (s_data),
    .i_rd_en   (w_pop),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign dac_ddata  = r_out_zero ? {DMA_DATA_WIDTH{1'b0}} : w_rd_data;
  assign dac_dunf   = r_dunf;
  assign unf_count  = r_unf_cnt;
  assign fill_level = r_level;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_dma_fifo.sv
// Randomized bench for the TPL DAC DMA FIFO against a queue-based model,
// plus directed threshold, underflow, clear-race, disable and reset scenarios.
module tb_ad_ip_jesd204_tpl_dac_dma_fifo;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_RUN   = 2;
  localparam int M_FLUSH = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          dac_valid;
  logic [DW-1:0] dac_ddata;
  logic          ctrl_enable;
  logic [AW:0]   ctrl_threshold;
  logic          dac_dunf;
  logic          dac_dunf_clr;
  logic [15:0]   unf_count;
  logic [AW:0]   fill_level;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_dma_fifo #(
    .DMA_DATA_WIDTH (DW),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .dac_valid      (dac_valid),
    .dac_ddata      (dac_ddata),
    .ctrl_enable    (ctrl_enable),
    .ctrl_threshold (ctrl_threshold),
    .dac_dunf       (dac_dunf),
    .dac_dunf_clr   (dac_dunf_clr),
    .unf_count      (unf_count),
    .fill_level     (fill_level)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue of words plus the operating mode.
  logic [63:0] mq[$];
  int          m_mode;
  logic [63:0] m_ddata;
  logic        m_dunf;
  int          m_cnt;
  logic [63:0] seq;
  bit          rand_data;

  // One clock: inputs already set by the caller; data word chosen here.
  task automatic cycle();
    bit          push;
    bit          pop;
    bit          unf;
    bit          ready;
    logic [63:0] d;
    d      = rand_data ? {$urandom, $urandom} : seq;
    s_data = d;
    ready  = ((m_mode == M_PRIME) || (m_mode == M_RUN)) && (mq.size() < DEPTH);
    if (reset) begin
      mq.delete();
      m_mode  = M_IDLE;
      m_ddata = 64'd0;
      m_dunf  = 1'b0;
      m_cnt   = 0;
    end else begin
      push = s_valid && ready;
      pop  = (m_mode == M_RUN) && dac_valid && (mq.size() > 0);
      unf  = (m_mode == M_RUN) && dac_valid && (mq.size() == 0);
      case (m_mode)
        M_IDLE:  if (ctrl_enable) m_mode = M_PRIME;
        M_PRIME: begin
          if (!ctrl_enable) m_mode = M_FLUSH;
          else if ((mq.size() >= int'(ctrl_threshold)) || (mq.size() == DEPTH)) m_mode = M_RUN;
        end
        M_RUN:   if (!ctrl_enable) m_mode = M_FLUSH;
        default: begin
          mq.delete();
          m_ddata = 64'd0;
          m_cnt   = 0;
          m_mode  = M_IDLE;
        end
      endcase
      if (pop) m_ddata = mq.pop_front();
      else if (unf) m_ddata = 64'd0;
      if (push) begin
        mq.push_back(d);
        if (!rand_data) seq++;
      end
      if (unf && (m_cnt < 65535)) m_cnt++;
      if (unf) m_dunf = 1'b1;
      else if (dac_dunf_clr) m_dunf = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    ready = ((m_mode == M_PRIME) || (m_mode == M_RUN)) && (mq.size() < DEPTH);
    check("s_ready",    64'(s_ready),    64'(ready));
    check("fill_level", 64'(fill_level), 64'(mq.size()));
    check("dac_ddata",  dac_ddata,       m_ddata);
    check("dac_dunf",   64'(dac_dunf),   64'(m_dunf));
    check("unf_count",  64'(unf_count),  64'(m_cnt));
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [63:0] exp_unf_seq [4];

  initial begin
    exp_unf_seq[0] = 64'd1;
    exp_unf_seq[1] = 64'd2;
    exp_unf_seq[2] = 64'd0;
    exp_unf_seq[3] = 64'd0;
    reset = 1'b1; s_valid = 1'b0; dac_valid = 1'b0; ctrl_enable = 1'b0;
    ctrl_threshold = 5'd0; dac_dunf_clr = 1'b0; s_data = 64'd0;
    rand_data = 1'b0; seq = 64'd1;
    mq.delete(); m_mode = M_IDLE; m_ddata = 64'd0; m_dunf = 1'b0; m_cnt = 0;
    run_n(2);
    reset = 1'b0;
    check("rst_ready", 64'(s_ready),    64'd0);
    check("rst_level", 64'(fill_level), 64'd0);
    check("rst_ddata", dac_ddata,       64'd0);
    check("rst_cnt",   64'(unf_count),  64'd0);

    // Threshold start: words 1..8, threshold 8
    ctrl_threshold = 5'd8; ctrl_enable = 1'b1; seq = 64'd1;
    cycle();
    s_valid = 1'b1; run_n(8); s_valid = 1'b0;
    check("thr_level", 64'(fill_level), 64'd8);
    cycle();
    dac_valid = 1'b1; cycle();
    check("thr_first", dac_ddata, 64'd1);
    run_n(7); dac_valid = 1'b0;

    // Underflow: two words then four reads
    ctrl_enable = 1'b0; run_n(2);
    ctrl_threshold = 5'd2; ctrl_enable = 1'b1; seq = 64'd1;
    cycle();
    s_valid = 1'b1; run_n(2); s_valid = 1'b0;
    cycle();
    dac_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("unf_seq", dac_ddata, exp_unf_seq[i]);
    end
    dac_valid = 1'b0;
    check("unf_flag", 64'(dac_dunf),  64'd1);
    check("unf_cnt",  64'(unf_count), 64'd2);

    // Clear race, then clear alone
    dac_valid = 1'b1; dac_dunf_clr = 1'b1; cycle();
    check("clr_race", 64'(dac_dunf), 64'd1);
    dac_valid = 1'b0; cycle();
    check("clr_alone", 64'(dac_dunf), 64'd0);
    dac_dunf_clr = 1'b0;

    // Disable with five words queued
    s_valid = 1'b1; run_n(5); s_valid = 1'b0;
    check("dis_level", 64'(fill_level), 64'd5);
    ctrl_enable = 1'b0; cycle();
    check("flush_ready", 64'(s_ready), 64'd0);
    cycle();
    check("idle_level", 64'(fill_level), 64'd0);
    check("idle_ddata", dac_ddata,       64'd0);
    check("idle_ready", 64'(s_ready),    64'd0);

    // Reset while running with nine words
    ctrl_threshold = 5'd0; ctrl_enable = 1'b1; run_n(2);
    s_valid = 1'b1; run_n(9);
    dac_valid = 1'b1; cycle();
    check("pushpop_level", 64'(fill_level), 64'd9);
    s_valid = 1'b0; dac_valid = 1'b0;
    reset = 1'b1; cycle(); reset = 1'b0;
    check("rrst_level", 64'(fill_level), 64'd0);
    check("rrst_ddata", dac_ddata,       64'd0);
    check("rrst_ready", 64'(s_ready),    64'd0);
    cycle();
    check("restart_ready", 64'(s_ready), 64'd1);

    // Full and wrap with random data and irregular reads
    rand_data = 1'b1; ctrl_threshold = 5'd0;
    s_valid = 1'b1; run_n(20);
    for (int i = 0; i < 300; i++) begin
      s_valid   = ($urandom_range(0, 3) != 0);
      dac_valid = ($urandom_range(0, 2) == 0);
      cycle();
    end

    // Fully random operation
    for (int i = 0; i < 2000; i++) begin
      s_valid      = ($urandom_range(0, 1) == 1);
      dac_valid    = ($urandom_range(0, 2) != 0);
      dac_dunf_clr = ($urandom_range(0, 7) == 0);
      reset        = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) ctrl_enable = ~ctrl_enable;
      if ($urandom_range(0, 99) == 0) ctrl_threshold = 5'($urandom_range(0, 20));
      cycle();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
